// File: rtl/lsu_mem_interface_if.sv
// Data-memory bus between the MEM-stage load/store unit and data memory.
// The LSU is the master (request side); memory is the slave (grant/response side).
interface lsu_mem_interface_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_interface.sv
// RV32I MEM-stage load/store unit: byte enables, store lane replication,
// req/gnt/rvalid handshake with data memory, pipeline stall and load alignment.
module lsu_mem_interface #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  misalign,
  output logic                  ld_valid,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic [2:0]            ld_sel,
  lsu_mem_interface_if.master   mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state;
  logic [1:0]            off;
  logic [1:0]            off_q;
  logic                  is_misaligned;
  logic                  accept;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [2:0]            sel_next;

  assign off = req_addr[1:0];

  // Halfwords (H/HU) need an even offset, words need offset 0.
  assign is_misaligned = ((req_funct3[1:0] == 2'b01) && off[0]) ||
                         ((req_funct3 == 3'b010) && (off != 2'b00));

  assign accept = (state == IDLE) && req_valid && !is_misaligned;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    be_next    = 4'b0000;
    wdata_next = req_wdata;
    sel_next   = 3'd7;
    case (req_funct3)
      3'b000: begin
        be_next    = 4'b0001 << off;
        wdata_next = {(DATA_WIDTH/8){req_wdata[7:0]}};
        sel_next   = 3'd2;
      end
      3'b100: begin
        be_next    = 4'b0001 << off;
        wdata_next = {(DATA_WIDTH/8){req_wdata[7:0]}};
        sel_next   = 3'd3;
      end
      3'b001: begin
        be_next    = 4'b0011 << off;
        wdata_next = {(DATA_WIDTH/16){req_wdata[15:0]}};
        sel_next   = 3'd1;
      end
      3'b101: begin
        be_next    = 4'b0011 << off;
        wdata_next = {(DATA_WIDTH/16){req_wdata[15:0]}};
        sel_next   = 3'd4;
      end
      3'b010: begin
        be_next  = 4'b1111;
        sel_next = 3'd0;
      end
      default: ;
    endcase
  end

  // Stall is raised in the accept cycle itself so the pipeline freezes immediately.
  assign stall    = !rst && (accept || (state == REQ) || (state == WAIT));
  assign misalign = !rst && (state == IDLE) && req_valid && is_misaligned;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      off_q         <= 2'b00;
      ld_valid      <= 1'b0;
      ld_data       <= '0;
      ld_sel        <= 3'd0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= 4'b0000;
    end else begin
      ld_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= req_we;
            mem.mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem.mem_wdata <= wdata_next;
            mem.mem_be    <= be_next;
            ld_sel        <= sel_next;
            off_q         <= off;
            state         <= REQ;
          end
        end
        REQ: begin
          // A response arriving before the grant is not ours and is ignored.
          if (mem.mem_gnt) begin
            mem.mem_req <= 1'b0;
            state       <= mem.mem_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            ld_data  <= mem.mem_rdata >> {off_q, 3'b000};
            ld_valid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_interface.sv
// Directed bench for lsu_mem_interface: loads, stores, misalignment, stretched
// handshakes and reset while a response is outstanding.
module tb_lsu_mem_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        misalign;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic [2:0]  ld_sel;

  int total = 0;
  int bad   = 0;
  int ld_pulses = 0;
  int pulses_before;

  lsu_mem_interface_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_mem_interface #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .misalign   (misalign),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_sel     (ld_sel),
    .mem        (bus.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ld_valid === 1'b1) ld_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and checks happen well after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    tick();

    // Reset state, and stall/misalign forced low while rst is high
    check("rst_stall",    {31'b0, stall},     32'd0);
    check("rst_misalign", {31'b0, misalign},  32'd0);
    check("rst_ld_valid", {31'b0, ld_valid},  32'd0);
    check("rst_ld_data",  ld_data,            32'd0);
    check("rst_ld_sel",   {29'b0, ld_sel},    32'd0);
    check("rst_mem_req",  {31'b0, bus.mem_req}, 32'd0);
    check("rst_mem_we",   {31'b0, bus.mem_we},  32'd0);
    check("rst_mem_addr", bus.mem_addr,       32'd0);
    check("rst_mem_wdata", bus.mem_wdata,     32'd0);
    check("rst_mem_be",   {28'b0, bus.mem_be}, 32'd0);
    set_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    check("rst_stall_forced", {31'b0, stall}, 32'd0);
    set_req(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    check("rst_misalign_forced", {31'b0, misalign}, 32'd0);
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Load word aligned: cycle 0 accept
    set_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    check("lw_c0_stall", {31'b0, stall}, 32'd1);
    check("lw_c0_misalign", {31'b0, misalign}, 32'd0);
    tick(); // cycle 1 REQ
    check("lw_c1_req",  {31'b0, bus.mem_req}, 32'd1);
    check("lw_c1_we",   {31'b0, bus.mem_we}, 32'd0);
    check("lw_c1_addr", bus.mem_addr, 32'h100);
    check("lw_c1_be",   {28'b0, bus.mem_be}, 32'hF);
    check("lw_c1_stall", {31'b0, stall}, 32'd1);
    bus.mem_gnt = 1'b1;
    tick(); // cycle 2 WAIT
    bus.mem_gnt = 1'b0;
    check("lw_c2_req",   {31'b0, bus.mem_req}, 32'd0);
    check("lw_c2_stall", {31'b0, stall}, 32'd1);
    check("lw_c2_ldv",   {31'b0, ld_valid}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    tick(); // cycle 3 DONE
    bus.mem_rvalid = 1'b0;
    check("lw_c3_ldv",   {31'b0, ld_valid}, 32'd1);
    check("lw_c3_data",  ld_data, 32'hDEADBEEF);
    check("lw_c3_sel",   {29'b0, ld_sel}, 32'd0);
    check("lw_c3_stall", {31'b0, stall}, 32'd0);
    check("lw_c3_req",   {31'b0, bus.mem_req}, 32'd0);
    tick(); // IDLE
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("lw_c4_ldv", {31'b0, ld_valid}, 32'd0);

    // Load byte, offset 3
    set_req(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    check("lb_c0_stall", {31'b0, stall}, 32'd1);
    tick();
    check("lb_c1_addr", bus.mem_addr, 32'h100);
    check("lb_c1_be",   {28'b0, bus.mem_be}, 32'h8);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h80AABBCC;
    tick();
    bus.mem_rvalid = 1'b0;
    check("lb_ldv",  {31'b0, ld_valid}, 32'd1);
    check("lb_data", ld_data, 32'h00000080);
    check("lb_sel",  {29'b0, ld_sel}, 32'd2);
    tick(); // IDLE directly after DONE: back-to-back store

    // Store halfword
    set_req(1'b1, 1'b1, 3'b001, 32'h202, 32'h1234ABCD);
    check("sh_c0_stall", {31'b0, stall}, 32'd1);
    tick();
    check("sh_c1_req",   {31'b0, bus.mem_req}, 32'd1);
    check("sh_c1_we",    {31'b0, bus.mem_we}, 32'd1);
    check("sh_c1_addr",  bus.mem_addr, 32'h200);
    check("sh_c1_be",    {28'b0, bus.mem_be}, 32'hC);
    check("sh_c1_wdata", bus.mem_wdata, 32'hABCDABCD);
    check("sh_c1_stall", {31'b0, stall}, 32'd1);
    bus.mem_gnt = 1'b1;
    tick(); // DONE
    bus.mem_gnt = 1'b0;
    check("sh_c2_stall", {31'b0, stall}, 32'd0);
    check("sh_c2_ldv",   {31'b0, ld_valid}, 32'd0);
    check("sh_c2_req",   {31'b0, bus.mem_req}, 32'd0);
    check("sh_c2_wdata", bus.mem_wdata, 32'hABCDABCD);
    tick();
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("sh_c3_ldv", {31'b0, ld_valid}, 32'd0);

    // Misaligned word, then misaligned HU
    set_req(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    check("mw_misalign", {31'b0, misalign}, 32'd1);
    check("mw_stall",    {31'b0, stall}, 32'd0);
    tick();
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("mw_misalign_off", {31'b0, misalign}, 32'd0);
    check("mw_no_req",   {31'b0, bus.mem_req}, 32'd0);
    set_req(1'b1, 1'b0, 3'b101, 32'h105, 32'h0);
    check("mhu_misalign", {31'b0, misalign}, 32'd1);
    check("mhu_stall",    {31'b0, stall}, 32'd0);
    tick();
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("mhu_no_req",   {31'b0, bus.mem_req}, 32'd0);
    tick();
    check("mhu_no_req2",  {31'b0, bus.mem_req}, 32'd0);

    // Illegal funct3 load still completes with be=0 and ld_sel=7
    set_req(1'b1, 1'b0, 3'b011, 32'h010, 32'h0);
    check("ill_stall", {31'b0, stall}, 32'd1);
    tick();
    check("ill_be", {28'b0, bus.mem_be}, 32'h0);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h12345678;
    tick();
    bus.mem_rvalid = 1'b0;
    check("ill_ldv",  {31'b0, ld_valid}, 32'd1);
    check("ill_sel",  {29'b0, ld_sel}, 32'd7);
    check("ill_data", ld_data, 32'h12345678);
    tick();
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

    // Delayed grant (3 idle REQ cycles) and response (2 idle WAIT cycles), HU at 0x302
    pulses_before = ld_pulses;
    set_req(1'b1, 1'b0, 3'b101, 32'h302, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.mem_rvalid = (i == 1);
      bus.mem_rdata  = 32'hFFFFFFFF;
      check("dl_req_hold",   {31'b0, bus.mem_req}, 32'd1);
      check("dl_addr_hold",  bus.mem_addr, 32'h300);
      check("dl_be_hold",    {28'b0, bus.mem_be}, 32'hC);
      check("dl_we_hold",    {31'b0, bus.mem_we}, 32'd0);
      check("dl_stall_req",  {31'b0, stall}, 32'd1);
    end
    tick();
    bus.mem_rvalid = 1'b0;
    check("dl_req_gnt_cycle", {31'b0, bus.mem_req}, 32'd1);
    check("dl_addr_gnt_cycle", bus.mem_addr, 32'h300);
    bus.mem_gnt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.mem_gnt = 1'b0;
      check("dl_req_off",    {31'b0, bus.mem_req}, 32'd0);
      check("dl_stall_wait", {31'b0, stall}, 32'd1);
      check("dl_ldv_wait",   {31'b0, ld_valid}, 32'd0);
    end
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE1234;
    check("dl_stall_last", {31'b0, stall}, 32'd1);
    tick();
    bus.mem_rvalid = 1'b0;
    check("dl_ldv",  {31'b0, ld_valid}, 32'd1);
    check("dl_data", ld_data, 32'h0000CAFE);
    check("dl_sel",  {29'b0, ld_sel}, 32'd4);
    tick();
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    check("dl_pulse_count", ld_pulses - pulses_before, 32'd1);

    // Reset while in WAIT, stray rvalid afterwards
    pulses_before = ld_pulses;
    set_req(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    tick();
    bus.mem_gnt = 1'b1;
    tick(); // WAIT
    bus.mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("rw_stall_forced", {31'b0, stall}, 32'd0);
    tick(); // reset taken
    rst = 1'b0;
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55555555;
    #1;
    check("rw_stall",    {31'b0, stall}, 32'd0);
    check("rw_misalign", {31'b0, misalign}, 32'd0);
    check("rw_ldv",      {31'b0, ld_valid}, 32'd0);
    check("rw_ld_data",  ld_data, 32'd0);
    check("rw_ld_sel",   {29'b0, ld_sel}, 32'd0);
    check("rw_mem_req",  {31'b0, bus.mem_req}, 32'd0);
    check("rw_mem_addr", bus.mem_addr, 32'd0);
    check("rw_mem_be",   {28'b0, bus.mem_be}, 32'd0);
    tick();
    bus.mem_rvalid = 1'b0;
    check("rw_stray_ldv", {31'b0, ld_valid}, 32'd0);
    check("rw_stray_data", ld_data, 32'd0);
    check("rw_no_pulse", ld_pulses - pulses_before, 32'd0);

    // Subsequent load completes normally: BU at offset 1
    set_req(1'b1, 1'b0, 3'b100, 32'h405, 32'h0);
    check("rl_stall", {31'b0, stall}, 32'd1);
    tick();
    check("rl_addr", bus.mem_addr, 32'h404);
    check("rl_be",   {28'b0, bus.mem_be}, 32'h2);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1122F033;
    tick();
    bus.mem_rvalid = 1'b0;
    check("rl_ldv",  {31'b0, ld_valid}, 32'd1);
    check("rl_data", ld_data, 32'h001122F0);
    check("rl_sel",  {29'b0, ld_sel}, 32'd3);
    tick();
    set_req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    check("rl_idle_ldv", {31'b0, ld_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_interface.md
# lsu_mem_interface

Load/store interface for the MEM stage of the 5-stage RV32I pipeline. It accepts one load or store per instruction and computes byte enables and lane-replicated store data. It runs a request/grant/response handshake with data memory and stalls the pipeline until the access completes. For loads it right-aligns the returned word and drives the raw data plus the 3-bit extension select to the downstream sign/zero-extension unit.

## Interface
- DATA_WIDTH, 32, data word width (fixed at 32 for RV32I; byte lanes = DATA_WIDTH/8)
- ADDR_WIDTH, 32, byte-address width
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  MEM stage holds a load/store; held stable while stall=1
- req_we  input  1  1=store, 0=load
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  ADDR_WIDTH  effective byte address
- req_wdata  input  DATA_WIDTH  store data (rs2)
- stall  output  1  freeze IF..MEM while an access is in flight
- misalign  output  1  one-cycle pulse, misaligned access rejected
- ld_valid  output  1  one-cycle pulse, load result valid
- ld_data  output  DATA_WIDTH  loaded word shifted so the addressed byte is at [7:0]
- ld_sel  output  3  extension select: 0 W, 1 H, 2 B, 3 BU, 4 HU, 7 illegal (extends to 0)
- mem_req  output  1  memory request valid
- mem_we  output  1  memory write
- mem_addr  output  ADDR_WIDTH  word-aligned address (req_addr with [1:0]=00)
- mem_wdata  output  DATA_WIDTH  lane-replicated store data
- mem_be  output  4  byte enables
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data valid; never in the same cycle as its grant
- mem_rdata  input  DATA_WIDTH  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- Offset `off` = req_addr[1:0].
- Misaligned access: H/HU with off[0]=1, or W with off≠00. In IDLE with req_valid and a misaligned access:
  - misalign=1 combinationally
  - no memory request, stall=0, stay in IDLE (the pipeline flushes on the exception)
- IDLE with req_valid and an aligned access:
  - stall=1 combinationally
  - capture we, funct3, off, addr, wdata into registers
  - go to REQ
- REQ: mem_req=1 with registered fields.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT.
  - mem_rvalid in REQ is ignored.
- WAIT: mem_req=0. On mem_rvalid, register ld_data = mem_rdata >> (8·off) (upper bits zero-filled) and go to DONE.
- DONE: stall=0; ld_valid=1 for loads only. Go to IDLE. req_valid is ignored in DONE, because the same instruction is leaving MEM that cycle.
- Byte enables:
  - B/BU: 0001<<off
  - H/HU: 0011<<off
  - W: 1111
  - Illegal funct3 (011, 110, 111): 0000; the transaction still completes, with ld_sel=7.
- Store data:
  - B: byte replicated to all 4 lanes
  - H: halfword replicated to both halves
  - W: unchanged
- ld_sel mapping from funct3: 000→2, 001→1, 010→0, 100→3, 101→4, other→7. ld_sel is registered at acceptance.
- rst in any state: go to IDLE next cycle. An outstanding response is dropped; a stray mem_rvalid seen in IDLE is ignored.

## Timing
- Reset values: stall 0, misalign 0, ld_valid 0, ld_data 0, ld_sel 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0. While rst=1, stall and misalign are forced to 0.
- mem_* outputs are registered and stable from REQ entry until the cycle after the grant. mem_req deasserts the cycle after mem_gnt.
- Load with immediate grant and rvalid one cycle later:
  - accept at cycle 0, REQ at 1 (gnt), WAIT at 2 (rvalid), DONE at 3 (ld_valid)
  - total 4 cycles, with stall high on cycles 0–2
- Store with immediate grant: accept at 0, REQ at 1, DONE at 2. Stall is high on cycles 0–1.
- Each cycle without mem_gnt adds one REQ cycle; each cycle without mem_rvalid adds one WAIT cycle. There is no timeout.
- Back-to-back accesses: a new request can be accepted in the IDLE cycle directly after DONE. At most one access is outstanding.

## Test plan
- Load word, aligned: addr=0x100, funct3=010, gnt at cycle 1, rvalid at cycle 2 with 0xDEADBEEF. Required:
  - mem_addr=0x100, be=1111
  - ld_valid at cycle 3 with ld_data=0xDEADBEEF, ld_sel=0
  - stall high on cycles 0–2
- Load byte, offset 3: addr=0x103, funct3=000, rdata=0x80AABBCC. Required: be=1000, ld_data=0x00000080, ld_sel=2.
- Store halfword: addr=0x202, funct3=001, wdata=0x1234ABCD. Required: mem_we=1, mem_addr=0x200, be=1100, mem_wdata=0xABCDABCD, no ld_valid, stall released after the grant cycle.
- Misaligned word: addr=0x101, funct3=010. Required: misalign pulse in the same cycle, mem_req never asserted, stall=0. Also check HU at addr 0x105 gives the same result.
- Delayed grant and response: gnt after 3 cycles, rvalid after 2 more. Required: mem_* outputs stable throughout REQ, stall held high, ld_valid exactly once.
- Reset mid-WAIT: assert rst in WAIT, then drive rvalid afterwards. Required: IDLE with all outputs 0 after the reset cycle, no ld_valid, and a subsequent load completes normally.
